paddle_swing_judge: RTL and testbench
=====================================

Name: paddle_swing_judge

Overview:
- Input-side companion of the ping-pong game core. Takes raw player switches (left = sw15, right = sw0) and the ball position/direction that the core drives onto the LED bar.
- Synchronizes and debounces each switch and detects swings.
- Judges each swing against the ball's position and emits one-cycle hit/miss events for the core's state machine and score logic.

Parameters:
- DEB_CYCLES, 625000, consecutive stable clocks needed to accept a switch change (6.25 ms at 100 MHz). Benches set 4.
- LOCK_TICKS, 2, game_tick strobes a player stays locked out after any judged swing.
- POS_W, 4, width of the ball position bus (LED index 0..15).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- sw_left  in  1  raw left-player switch (sw15), asynchronous
- sw_right  in  1  raw right-player switch (sw0), asynchronous
- ball_pos  in  POS_W  current ball LED index; 15 = left end, 0 = right end
- ball_dir  in  1  1 = moving toward left (index increasing), 0 = toward right
- game_tick  in  1  one-clk strobe; core advances ball_pos on the clock edge where this is high
- hit_left  out  1  one-cycle pulse: valid left return
- hit_right  out  1  one-cycle pulse: valid right return
- miss_left  out  1  one-cycle pulse: left player failed to return
- miss_right  out  1  one-cycle pulse: right player failed to return

Behaviour:
- Reset: all outputs 0, both FSMs IDLE, debounce counters 0, synchronizer flops 1, debounced levels 1.
  - Debounced level resets to 1, so a switch held through reset produces no swing until it is released and pressed again.
- Sync: each raw input passes through a 2-flop synchronizer.
- Debounce, per player:
  - Counter clears whenever the synced value equals the debounced level.
  - Otherwise it increments; on reaching DEB_CYCLES-1 the debounced level flips and the counter clears.
  - Counter width is $clog2(DEB_CYCLES).
- Swing event: debounced 0->1 transition, one clk.
  - Latency from a stable raw edge to the swing event is 2 + DEB_CYCLES clocks.
- At-end condition:
  - Left: ball_pos == 15 && ball_dir == 1.
  - Right: ball_pos == 0 && ball_dir == 0.
- Per-player FSM, states IDLE, LOCK:
  - IDLE, swing while at-end -> hit pulse on the next clk; go LOCK.
  - IDLE, swing while not at-end (early swing) -> no pulse; go LOCK.
  - IDLE, game_tick while at-end and no hit issued for this ball visit -> miss pulse on the next clk; stay IDLE.
  - LOCK: swings ignored. The lock counter counts game_tick strobes.
  - LOCK exits to IDLE when the count reaches LOCK_TICKS AND the debounced level is 0 (switch released).
  - A held switch therefore extends LOCK indefinitely.
  - LOCK still issues a miss if game_tick arrives while at-end and no hit was issued for this visit. This is the early-swing penalty.
- Visit flag, per player:
  - Set when a hit is issued.
  - Cleared when the at-end condition goes false.
  - Prevents a second hit or a miss in the same visit.
- Simultaneous swing and game_tick while at-end, same clk: swing is judged against the pre-tick ball_pos. Hit wins; miss is suppressed.
- Both players act in the same clk: judged independently. At most one player can be at-end, so at most one hit.
- Outputs are registered; no pulse is ever wider than 1 clk.
- Reset asserted mid-operation: outputs drop to 0 immediately (asynchronously); all state returns to its reset value.

Optional Feature:
- Macro PADDLE_AUTOPLAY_EN.
- Defined: sw_left/sw_right are ignored. Each player gets a synthetic swing event on the first clk of every at-end visit, giving an endless rally demo. Debounce logic is still compiled but unused. Miss outputs never pulse.
- Undefined: normal switch-driven behaviour as above. The ports list is identical in both builds.

Test Plan (DEB_CYCLES=4, LOCK_TICKS=2):
- Reset with sw_left=1, release rst_n, hold sw_left=1 for 50 clks at ball_pos=15, ball_dir=1 -> no hit_left. A single miss_left pulses 1 clk after the first game_tick.
- sw_left 0->1 stable, ball_pos=15, ball_dir=1, no tick -> hit_left high exactly 1 clk, 7 clks after the raw edge. No miss_left on the next game_tick at pos 15.
- sw_right pulses high at ball_pos=5, ball_dir=0; ball reaches 0 within 2 ticks; second sw_right press at pos 0 -> no hit_right (locked). miss_right fires 1 clk after the tick at pos 0.
- Glitch sw_left high for 3 clks only -> debounced level unchanged; no pulse on any output.
- Swing event and game_tick in the same clk at ball_pos=0, ball_dir=0 -> hit_right=1 for 1 clk; miss_right stays 0.
- Drop rst_n while in LOCK with hit_left high -> all outputs 0 in the same cycle. After release, FSM is IDLE and the next valid swing at pos 15 produces hit_left.

Source files
------------

// File: rtl/paddle_swing_judge.sv
// Paddle input judge for the ping-pong core: sync + debounce per switch, swing detect,
// hit/miss judgement against the ball. Define PADDLE_AUTOPLAY_EN for the endless-rally demo build.
module paddle_swing_judge #(
  parameter int DEB_CYCLES = 625000,
  parameter int LOCK_TICKS = 2,
  parameter int POS_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_left,
  input  logic             sw_right,
  input  logic [POS_W-1:0] ball_pos,
  input  logic             ball_dir,
  input  logic             game_tick,
  output logic             hit_left,
  output logic             hit_right,
  output logic             miss_left,
  output logic             miss_right
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int LW = $clog2(LOCK_TICKS + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  // Index 1 = left player, index 0 = right player throughout.
  logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [CW-1:0] cnt_q [2];
  state_t        state_q [2];
  logic [LW-1:0] lock_q [2];
  logic [1:0]    visit_q, hit_q, miss_q, at_end_prev_q;

  logic [1:0] raw, at_end, swing, released, hit_d, miss_d;

  assign raw       = {sw_left, sw_right};
  assign at_end[1] = (ball_pos == '1) && ball_dir;
  assign at_end[0] = (ball_pos == '0) && !ball_dir;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    swing    = '0;
    released = '0;
    hit_d    = '0;
    miss_d   = '0;
    for (int p = 0; p < 2; p++) begin
`ifdef PADDLE_AUTOPLAY_EN
      swing[p]    = at_end[p] && !at_end_prev_q[p];
      released[p] = 1'b1;
`else
      swing[p]    = deb_q[p] && !deb_prev_q[p];
      released[p] = !deb_q[p];
`endif
      // A swing in the same clk as a tick is judged on the pre-tick position; hit wins.
      hit_d[p] = (state_q[p] == IDLE) && swing[p] && at_end[p] && !visit_q[p];
`ifndef PADDLE_AUTOPLAY_EN
      miss_d[p] = game_tick && at_end[p] && !visit_q[p] && !hit_d[p];
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 2'b11;
      sync2_q       <= 2'b11;
      deb_q         <= 2'b11;
      deb_prev_q    <= 2'b11;
      visit_q       <= '0;
      hit_q         <= '0;
      miss_q        <= '0;
      at_end_prev_q <= '0;
      for (int p = 0; p < 2; p++) begin
        cnt_q[p]   <= '0;
        state_q[p] <= IDLE;
        lock_q[p]  <= '0;
      end
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      deb_prev_q    <= deb_q;
      at_end_prev_q <= at_end;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      for (int p = 0; p < 2; p++) begin
        if (sync2_q[p] == deb_q[p]) begin
          cnt_q[p] <= '0;
        end else if (cnt_q[p] == CW'(DEB_CYCLES - 1)) begin
          deb_q[p] <= !deb_q[p];
          cnt_q[p] <= '0;
        end else begin
          cnt_q[p] <= cnt_q[p] + 1'b1;
        end

        visit_q[p] <= at_end[p] && (visit_q[p] || hit_d[p]);

        case (state_q[p])
          IDLE: begin
            if (swing[p]) begin
              state_q[p] <= LOCK;
              lock_q[p]  <= '0;
            end
          end
          LOCK: begin
            // A switch still held keeps the player locked out past the tick count.
            if (lock_q[p] >= LW'(LOCK_TICKS) && released[p]) begin
              state_q[p] <= IDLE;
            end else if (game_tick && lock_q[p] < LW'(LOCK_TICKS)) begin
              lock_q[p] <= lock_q[p] + 1'b1;
            end
          end
          default: state_q[p] <= IDLE;
        endcase
      end
    end
  end

  assign hit_left   = hit_q[1];
  assign hit_right  = hit_q[0];
  assign miss_left  = miss_q[1];
  assign miss_right = miss_q[0];

endmodule

// File: tb/tb_paddle_swing_judge.sv
// Directed bench for paddle_swing_judge with DEB_CYCLES=4, LOCK_TICKS=2.
// Outputs are compared as {hit_left, hit_right, miss_left, miss_right}.
module tb_paddle_swing_judge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_left, sw_right;
  logic [3:0] ball_pos;
  logic       ball_dir;
  logic       game_tick;
  logic       hit_left, hit_right, miss_left, miss_right;

  int passed = 0;
  int total  = 0;

  paddle_swing_judge #(.DEB_CYCLES(4), .LOCK_TICKS(2), .POS_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_left    (sw_left),
    .sw_right   (sw_right),
    .ball_pos   (ball_pos),
    .ball_dir   (ball_dir),
    .game_tick  (game_tick),
    .hit_left   (hit_left),
    .hit_right  (hit_right),
    .miss_left  (miss_left),
    .miss_right (miss_right)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {hit_left, hit_right, miss_left, miss_right};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Run n clocks and require that no output pulses anywhere in the window.
  task automatic quiet(input string tag, input int n);
    logic [3:0] seen;
    seen = '0;
    repeat (n) begin
      step(1);
      seen |= outs();
    end
    check(tag, seen, 4'b0000);
  endtask

  task automatic pulse_tick();
    game_tick = 1'b1;
    step(1);
    game_tick = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    sw_left   = 1'b1;
    sw_right  = 1'b0;
    ball_pos  = 4'd15;
    ball_dir  = 1'b1;
    game_tick = 1'b0;
    step(3);
    check("reset_outputs", outs(), 4'b0000);
    rst_n = 1'b1;

    // Left switch held through reset: no swing, one miss on the tick at the left end.
    quiet("held_through_reset", 50);
    pulse_tick();
    check("miss_left_after_tick", outs(), 4'b0010);
    ball_pos = 4'd14;
    ball_dir = 1'b0;
    step(1);
    check("miss_left_one_clk", outs(), 4'b0000);

    // Clean press at the left end: hit exactly 7 clks after the raw edge.
    sw_left = 1'b0;
    quiet("left_release", 10);
    ball_pos = 4'd15;
    ball_dir = 1'b1;
    sw_left  = 1'b1;
    quiet("left_press_latency", 6);
    step(1);
    check("hit_left_at_7", outs(), 4'b1000);
    step(1);
    check("hit_left_one_clk", outs(), 4'b0000);
    pulse_tick();
    check("no_miss_after_hit", outs(), 4'b0000);
    ball_pos = 4'd14;
    ball_dir = 1'b0;
    sw_left  = 1'b0;
    quiet("left_release_2", 10);

    // Early right swing locks the player; second press at the end is ignored, miss follows.
    ball_pos = 4'd5;
    sw_right = 1'b1;
    quiet("early_swing_right", 8);
    pulse_tick();
    check("tick_mid_field", outs(), 4'b0000);
    ball_pos = 4'd0;
    sw_right = 1'b0;
    quiet("right_release", 10);
    sw_right = 1'b1;
    quiet("locked_press_no_hit", 10);
    pulse_tick();
    check("miss_right_after_tick", outs(), 4'b0001);
    step(1);
    check("miss_right_one_clk", outs(), 4'b0000);
    sw_right = 1'b0;
    quiet("right_release_2", 10);

    // Swing event and tick in the same clk at the right end: hit wins, no miss.
    sw_right = 1'b1;
    quiet("right_press_latency", 6);
    pulse_tick();
    check("hit_right_beats_miss", outs(), 4'b0100);
    step(1);
    check("hit_right_one_clk", outs(), 4'b0000);
    ball_pos = 4'd1;
    ball_dir = 1'b1;
    sw_right = 1'b0;
    quiet("right_release_3", 10);

    // Three-clock glitch at the left end is filtered out.
    ball_pos = 4'd15;
    ball_dir = 1'b1;
    sw_left  = 1'b1;
    step(3);
    sw_left  = 1'b0;
    quiet("glitch_filtered", 12);

    // Reset while hit_left is high clears outputs at once; FSM is usable afterwards.
    sw_left = 1'b1;
    quiet("left_press_latency_2", 6);
    step(1);
    check("hit_left_before_reset", outs(), 4'b1000);
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", outs(), 4'b0000);
    step(2);
    check("outputs_in_reset", outs(), 4'b0000);
    rst_n = 1'b1;
    quiet("held_after_reset", 10);
    sw_left = 1'b0;
    quiet("left_release_4", 10);
    sw_left = 1'b1;
    quiet("left_press_latency_3", 6);
    step(1);
    check("hit_left_after_reset", outs(), 4'b1000);
    step(1);
    check("hit_left_after_reset_one_clk", outs(), 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
